// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// datapath mux selects, ALU operations, data-processing commands and
// condition codes.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // ALUControl
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Instruction class (op field)
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing commands (funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    function automatic logic cmd_supported(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_AND) || (cmd == CMD_ORR);
    endfunction

    function automatic logic [1:0] cmd_to_alu(input logic [3:0] cmd);
        logic [1:0] v_alu;
        case (cmd)
            CMD_SUB: v_alu = ALU_SUB;
            CMD_AND: v_alu = ALU_AND;
            CMD_ORR: v_alu = ALU_ORR;
            default: v_alu = ALU_ADD;
        endcase
        return v_alu;
    endfunction

endpackage

// File: rtl/arm_multicycle_ctrl_condlogic.sv
// Condition logic: stored NZCV flags, CondEx evaluation and gating of the
// raw write enables coming from the FSM. Reset low forces every enable off
// in the same cycle so an aborted instruction cannot commit anything.
module condlogic
    import arm_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic [1:0] i_flag_w,
    input  logic       i_pc_fetch,
    input  logic       i_ir_w,
    input  logic       i_reg_w,
    input  logic       i_mem_w,
    input  logic       i_branch,
    input  logic       i_rd_is_pc,
    output logic       o_cond_ex,
    output logic       o_pc_write,
    output logic       o_ir_write,
    output logic       o_reg_write,
    output logic       o_mem_write
);

    logic [3:0] r_flags;
    logic       w_n, w_z, w_c, w_v;
    logic       w_cond_ex;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Evaluate the instruction condition against the stored flags
    always_comb begin
        w_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: w_cond_ex = w_z;
            COND_NE: w_cond_ex = ~w_z;
            COND_CS: w_cond_ex = w_c;
            COND_CC: w_cond_ex = ~w_c;
            COND_MI: w_cond_ex = w_n;
            COND_PL: w_cond_ex = ~w_n;
            COND_VS: w_cond_ex = w_v;
            COND_VC: w_cond_ex = ~w_v;
            COND_HI: w_cond_ex = w_c & ~w_z;
            COND_LS: w_cond_ex = ~w_c | w_z;
            COND_GE: w_cond_ex = (w_n == w_v);
            COND_LT: w_cond_ex = (w_n != w_v);
            COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: w_cond_ex = w_z | (w_n != w_v);
            COND_AL: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // NZ and CV halves of the flag register update independently, only when the instruction executes
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_flags <= 4'b0000;
        end else begin
            if (i_flag_w[1] && w_cond_ex) r_flags[3:2] <= i_alu_flags[3:2];
            if (i_flag_w[0] && w_cond_ex) r_flags[1:0] <= i_alu_flags[1:0];
        end
    end

    assign o_cond_ex   = w_cond_ex;
    assign o_pc_write  = i_rst_n & (i_pc_fetch | (i_branch & w_cond_ex) |
                                    (i_reg_w & w_cond_ex & i_rd_is_pc));
    assign o_ir_write  = i_rst_n & i_ir_w;
    assign o_reg_write = i_rst_n & i_reg_w & w_cond_ex;
    assign o_mem_write = i_rst_n & i_mem_w & w_cond_ex;

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle controller for the 32-bit ARM subset (DP reg/imm, LDR/STR, B).
// FSM and instruction decode live here; condlogic holds flags and gating.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   FETCH  | read instr at PC into IR, PC <= PC+4
//   DECODE | read registers, compute PC+8 for operand use
//   MEMADR | compute memory address Rn + imm
//   MEMRD  | read data memory at computed address
//   MEMWB  | write loaded data to Rd
//   MEMWR  | write register B to memory
//   EXECR  | ALU op with register operand
//   EXECI  | ALU op with immediate operand
//   ALUWB  | write ALU result to Rd
//   BRANCH | PC <= PC+8 + offset if condition holds
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl
);

    state_t     r_state;
    state_t     w_next;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic       w_imm_op;
    logic [3:0] w_cmd;
    logic       w_s_or_l;
    logic       w_add_sub;
    logic       w_unused;

    logic [1:0] w_imm_dec;
    logic [1:0] w_reg_dec;

    logic       w_pc_fetch;
    logic       w_ir_w;
    logic       w_reg_w;
    logic       w_mem_w;
    logic       w_branch;
    logic [1:0] w_flag_w;
    logic       w_cond_ex;

    // Instr holds bits [31:12] of the instruction word
    assign w_cond    = Instr[19:16];
    assign w_op      = Instr[15:14];
    assign w_funct   = Instr[13:8];
    assign w_rd      = Instr[3:0];
    assign w_imm_op  = w_funct[5];
    assign w_cmd     = w_funct[4:1];
    assign w_s_or_l  = w_funct[0];
    assign w_add_sub = (w_cmd == CMD_ADD) || (w_cmd == CMD_SUB);
    assign w_unused  = ^Instr[7:4];

    // Single-cycle style decode of immediate format and register read sources
    always_comb begin
        w_imm_dec = 2'b00;
        w_reg_dec = 2'b00;
        case (w_op)
            OP_DP: begin
                w_imm_dec = 2'b00;
                w_reg_dec = 2'b00;
            end
            OP_MEM: begin
                w_imm_dec = 2'b01;
                w_reg_dec = w_s_or_l ? 2'b00 : 2'b10;
            end
            OP_BR: begin
                w_imm_dec = 2'b10;
                w_reg_dec = 2'b01;
            end
            default: begin
                w_imm_dec = 2'b00;
                w_reg_dec = 2'b00;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Next-state logic; op=11 and unsupported DP commands fall back to FETCH
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_DP:   w_next = !cmd_supported(w_cmd) ? S_FETCH :
                                      (w_imm_op ? S_EXECI : S_EXECR);
                    OP_MEM:  w_next = S_MEMADR;
                    OP_BR:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = w_s_or_l ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Moore outputs per state; write enables leave here raw and are gated in condlogic
    always_comb begin
        w_pc_fetch = 1'b0;
        w_ir_w     = 1'b0;
        w_reg_w    = 1'b0;
        w_mem_w    = 1'b0;
        w_branch   = 1'b0;
        w_flag_w   = 2'b00;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_pc_fetch = 1'b1;
                w_ir_w     = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                ImmSrc     = w_imm_dec;
                RegSrc     = w_reg_dec;
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = w_imm_dec;
            end
            S_MEMRD: begin
                AdrSrc     = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = RES_MEMDATA;
                w_reg_w    = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc     = 1'b1;
                w_mem_w    = 1'b1;
            end
            S_EXECR: begin
                ALUSrcB    = SRCB_REG;
                ALUControl = cmd_to_alu(w_cmd);
                w_flag_w   = {w_s_or_l, w_s_or_l & w_add_sub};
            end
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = w_imm_dec;
                ALUControl = cmd_to_alu(w_cmd);
                w_flag_w   = {w_s_or_l, w_s_or_l & w_add_sub};
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                w_reg_w    = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURESULT;
                ImmSrc     = w_imm_dec;
                w_branch   = 1'b1;
            end
            default: begin
                w_pc_fetch = 1'b0;
            end
        endcase
    end

    condlogic u_condlogic (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_cond      (w_cond),
        .i_alu_flags (ALUFlags),
        .i_flag_w    (w_flag_w),
        .i_pc_fetch  (w_pc_fetch),
        .i_ir_w      (w_ir_w),
        .i_reg_w     (w_reg_w),
        .i_mem_w     (w_mem_w),
        .i_branch    (w_branch),
        .i_rd_is_pc  (w_rd == 4'hF),
        .o_cond_ex   (w_cond_ex),
        .o_pc_write  (PCWrite),
        .o_ir_write  (IRWrite),
        .o_reg_write (RegWrite),
        .o_mem_write (MemWrite)
    );

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Bench for arm_multicycle_ctrl: directed instruction sequences followed by
// random instructions and random reset aborts, every cycle's outputs compared
// with a per-instruction step model.
module tb_arm_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    logic [15:0] w_outs;
    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  m_flags;

    always #5 clk = ~clk;

    arm_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl)
    );

    assign w_outs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                     ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  r = z;
            4'd1:  r = !z;
            4'd2:  r = cy;
            4'd3:  r = !cy;
            4'd4:  r = n;
            4'd5:  r = !n;
            4'd6:  r = v;
            4'd7:  r = !v;
            4'd8:  r = cy && !z;
            4'd9:  r = !cy || z;
            4'd10: r = (n == v);
            4'd11: r = (n != v);
            4'd12: r = !z && (n == v);
            4'd13: r = z || (n != v);
            4'd14: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        logic [1:0] a;
        case (cmd)
            4'b0100: a = 2'b00;
            4'b0010: a = 2'b01;
            4'b0000: a = 2'b10;
            4'b1100: a = 2'b11;
            default: a = 2'b00;
        endcase
        return a;
    endfunction

    // Expected output bundle for one step of an instruction under flags f
    function automatic logic [15:0] exp_out(input string step, input logic [19:0] ins, input logic [3:0] f);
        logic       pcw, mw, rw, irw, adr, sa, ce, rdpc;
        logic [1:0] sb, res, imm, rs, alu, op;
        pcw = 0; mw = 0; rw = 0; irw = 0; adr = 0; sa = 0;
        sb = 0; res = 0; imm = 0; rs = 0; alu = 0;
        op   = ins[15:14];
        ce   = cond_holds(ins[19:16], f);
        rdpc = (ins[3:0] == 4'hF);
        if (step == "FETCH") begin
            pcw = 1; irw = 1; sa = 1; sb = 2'b10; res = 2'b10;
        end else if (step == "DECODE") begin
            sa = 1; sb = 2'b10; res = 2'b10;
            imm = (op == 2'b11) ? 2'b00 : op;
            if (op == 2'b01)      rs = ins[8] ? 2'b00 : 2'b10;
            else if (op == 2'b10) rs = 2'b01;
        end else if (step == "MEMADR") begin
            sb = 2'b01; imm = 2'b01;
        end else if (step == "MEMRD") begin
            adr = 1;
        end else if (step == "MEMWB") begin
            res = 2'b01; rw = ce; pcw = ce && rdpc;
        end else if (step == "MEMWR") begin
            adr = 1; mw = ce;
        end else if (step == "EXECR") begin
            sb = 2'b00; alu = alu_of(ins[12:9]);
        end else if (step == "EXECI") begin
            sb = 2'b01; alu = alu_of(ins[12:9]); imm = 2'b00;
        end else if (step == "ALUWB") begin
            res = 2'b00; rw = ce; pcw = ce && rdpc;
        end else if (step == "BRANCH") begin
            sb = 2'b01; res = 2'b10; imm = 2'b10; pcw = ce;
        end
        return {pcw, mw, rw, irw, adr, sa, sb, res, imm, rs, alu};
    endfunction

    // Run one instruction from FETCH; abort_at = step index where reset is pulled low
    task automatic run_instr(input logic [19:0] ins, input int abort_at,
                             input logic force_en, input logic [3:0] ff);
        string      steps[5];
        int         n;
        logic [3:0] cmd;
        logic       execs;
        cmd = ins[12:9];
        steps[0] = "FETCH";
        steps[1] = "DECODE";
        n = 2;
        if (ins[15:14] == 2'b00 && (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100})) begin
            steps[2] = ins[13] ? "EXECI" : "EXECR";
            steps[3] = "ALUWB";
            n = 4;
        end else if (ins[15:14] == 2'b01) begin
            steps[2] = "MEMADR";
            if (ins[8]) begin
                steps[3] = "MEMRD"; steps[4] = "MEMWB"; n = 5;
            end else begin
                steps[3] = "MEMWR"; n = 4;
            end
        end else if (ins[15:14] == 2'b10) begin
            steps[2] = "BRANCH";
            n = 3;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            Instr    = ins;
            ALUFlags = force_en ? ff : 4'($urandom);
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                chk("rst_en", w_outs & 16'hF000, 16'h0000);
                m_flags = 4'b0000;
                return;
            end
            reset = 1'b1;
            #1;
            chk(steps[k], w_outs, exp_out(steps[k], ins, m_flags));
            execs = (steps[k] == "EXECR") || (steps[k] == "EXECI");
            if (execs && ins[8] && cond_holds(ins[19:16], m_flags)) begin
                m_flags[3:2] = ALUFlags[3:2];
                if (cmd == 4'b0100 || cmd == 4'b0010) m_flags[1:0] = ALUFlags[1:0];
            end
        end
    endtask

    function automatic logic [19:0] rand_instr();
        logic [3:0] cond, cmd, rd;
        logic [1:0] op;
        logic [3:0] cmds[4];
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;
        cond = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
        op   = 2'($urandom_range(0, 3));
        cmd  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : cmds[$urandom_range(0, 3)];
        rd   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
        return {cond, op, 1'($urandom), cmd, 1'($urandom), 4'($urandom), rd};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        Instr    = 20'h0;
        ALUFlags = 4'h0;
        m_flags  = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            Instr = 20'($urandom);
            #1;
            chk("rst_hold", w_outs & 16'hF000, 16'h0000);
        end

        run_instr(20'hE0821, -1, 0, 4'h0);   // ADD R1,R2,R3
        run_instr(20'hE5921, -1, 0, 4'h0);   // LDR R1,[R2,#4]
        run_instr(20'hE5821, -1, 0, 4'h0);   // STR R1,[R2,#4]
        run_instr(20'hE0500, -1, 1, 4'b0100); // SUBS R0,R0,R0 -> Z
        run_instr(20'h0A000, -1, 0, 4'h0);   // BEQ taken
        run_instr(20'h1A000, -1, 0, 4'h0);   // BNE not taken
        run_instr(20'hE0500, -1, 1, 4'b0000); // SUBS clears Z
        run_instr(20'h00821, -1, 0, 4'h0);   // ADDEQ with Z=0
        run_instr(20'hE0500, -1, 1, 4'b1111); // SUBS sets NZCV
        run_instr(20'hE5921,  3, 0, 4'h0);   // LDR aborted in MEMRD
        run_instr(20'h0A000, -1, 0, 4'h0);   // BEQ after reset: flags cleared
        run_instr(20'h2A000, -1, 0, 4'h0);   // BCS after reset
        run_instr(20'h1A000, -1, 0, 4'h0);   // BNE after reset
        run_instr(20'hE0821,  0, 0, 4'h0);   // reset during FETCH
        run_instr(20'hE082F, -1, 0, 4'h0);   // ADD PC,...
        run_instr(20'hE5821,  3, 0, 4'h0);   // STR aborted in MEMWR
        run_instr(20'hF0821, -1, 0, 4'h0);   // cond=1111 never executes
        run_instr(20'hE0B21, -1, 0, 4'h0);   // unsupported cmd
        run_instr(20'hEC821, -1, 0, 4'h0);   // op=11

        for (int i = 0; i < 200; i++) begin
            int ab;
            ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(rand_instr(), ab, 0, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arm_multicycle_ctrl.md
ARM_MULTICYCLE_CTRL -- requirements
Module: arm_multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the 32-bit ARM subset.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-004 Instr  in  20  Instr[31:12] of the instruction register: cond[31:28], op[27:26], funct[25:20], Rd[15:12].
REQ-005 ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-006 PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  gated write enables.
REQ-007 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-008 ALUSrcA  out  1  0 = register A, 1 = PC.
REQ-009 ALUSrcB  out  2  00 = register B, 01 = ExtImm, 10 = constant 4.
REQ-010 ResultSrc  out  2  00 = ALU result register, 01 = memory data register, 10 = ALUResult direct.
REQ-011 ImmSrc, RegSrc, ALUControl  out  2 each  same encodings as the existing datapath; ALUControl 00 ADD, 01 SUB, 10 AND, 11 ORR.

Function
REQ-012 The FSM SHALL use the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, one state per cycle.
REQ-013 Transitions: FETCH->DECODE; DECODE->MEMADR (op=01), EXECR (op=00, I=0), EXECI (op=00, I=1), BRANCH (op=10); MEMADR->MEMRD (L=1) or MEMWR (L=0); MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-014 op=11 or an unsupported data-processing cmd SHALL return DECODE->FETCH with no write enable asserted.
REQ-015 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1 (unconditional).
REQ-016 DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10; RegSrc/ImmSrc decoded from op as in the single-cycle decoder.
REQ-017 MEMADR: ALUSrcA=0, ALUSrcB=01, ADD; MEMRD: AdrSrc=1; MEMWB: ResultSrc=01, RegW; MEMWR: AdrSrc=1, MemW.
REQ-018 EXECR: ALUSrcB=00, ALUControl from funct[4:1] (0100 ADD, 0010 SUB, 0000 AND, 1100 ORR); EXECI: same, ALUSrcB=01; ALUWB: ResultSrc=00, RegW.
REQ-019 BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, Branch.
REQ-020 Latency SHALL be 3 cycles (branch), 4 (data-processing, STR), 5 (LDR).
REQ-021 CondEx SHALL be evaluated from cond and the stored flag register for EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; cond=1111 SHALL be false.
REQ-022 RegWrite = RegW & CondEx; MemWrite = MemW & CondEx; PCWrite = FETCH | (Branch & CondEx) | (RegW & CondEx & Rd=1111).
REQ-023 Flag register SHALL update only at the end of EXECR/EXECI when S=1 and CondEx: NZ for all four cmds, CV additionally for ADD/SUB.
REQ-024 Outputs not listed for a state SHALL be 0; all enables SHALL be Moore outputs gated only by CondEx.

Reset
REQ-025 While reset=0: state<=FETCH, flags<=0000, all write enables driven 0 in that cycle.
REQ-026 Reset asserted mid-instruction SHALL abort it; no write enable asserts after the reset edge until FETCH restarts.
REQ-027 First cycle after reset release SHALL be FETCH with IRWrite=1, PCWrite=1.

Structure
REQ-028 Package arm_ctrl_pkg SHALL hold the state enum, ALUControl, ResultSrc, ALUSrcB encodings and the 4-bit condition-code constants.
REQ-029 One sub-module condlogic SHALL hold the flag register, CondEx evaluation and enable gating; FSM and decode stay in the top.

Verification
REQ-030 ADD R1,R2,R3 (0xE0821003): states FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in cycle 4; ALUControl=00 in EXECR.
REQ-031 LDR R1,[R2,#4] (0xE5921004): 5 cycles; AdrSrc=1 in MEMRD; RegWrite=1 with ResultSrc=01 in MEMWB.
REQ-032 STR (0xE5821004): MemWrite=1 only in MEMWR; RegWrite never 1.
REQ-033 SUBS R0,R0,R0 with ALUFlags=0100 -> Z latched; following BEQ (0x0A000002) asserts PCWrite in BRANCH; BNE (0x1A000002) does not.
REQ-034 ADD with cond=EQ while Z=0: no RegWrite in ALUWB; next state FETCH.
REQ-035 reset=0 during MEMRD of LDR: next state FETCH, no RegWrite issued; flags read back 0000.
